// File: rtl/updown_counter_fsm_pkg.sv
// Shared definitions for the up/down counter block.
// Holds the direction and run-state encodings and the limit-policy selectors.
package updown_counter_fsm_pkg;

    // Direction of travel. UP steps toward MAX_VAL, DOWN steps toward MIN_VAL.
    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    // Run state. PAUSED ignores ticks, RUNNING steps on every tick.
    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } run_e;

    // Limit policy selectors for the MODE parameter.
    localparam int MODE_WRAP   = 0;
    localparam int MODE_SAT    = 1;
    localparam int MODE_BOUNCE = 2;

endpackage

// File: rtl/updown_counter_fsm_dir_state_fsm.sv
// Direction state machine (UP/DOWN) for the up/down counter.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   increase_i    - one-cycle request for UP
//   decrease_i    - one-cycle request for DOWN
//   auto_flip_i   - reverse direction (bounce at a limit); a user request wins
//   dir_o         - registered direction, 0 = UP, 1 = DOWN
module dir_state_fsm
    import updown_counter_fsm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic increase_i,
    input  logic decrease_i,
    input  logic auto_flip_i,
    output logic dir_o
);

    dir_e dir_q;
    dir_e dir_d;

    // Direction register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q <= UP;
        end else begin
            dir_q <= dir_d;
        end
    end

    // Next direction: a single user request decides, both together hold,
    // otherwise a bounce flip applies.
    always_comb begin
        dir_d = dir_q;
        if (increase_i && !decrease_i) begin
            dir_d = UP;
        end else if (decrease_i && !increase_i) begin
            dir_d = DOWN;
        end else if (increase_i && decrease_i) begin
            dir_d = dir_q;
        end else if (auto_flip_i) begin
            dir_d = (dir_q == UP) ? DOWN : UP;
        end else begin
            dir_d = dir_q;
        end
    end

    assign dir_o = dir_q;

endmodule

// File: rtl/updown_counter_fsm.sv
// Bounded up/down counter with direction FSM, run/pause FSM and limit event.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   increase_processed  - pulse, request direction UP
//   decrease_processed  - pulse, request direction DOWN
//   pause_processed     - pulse, toggle RUNNING/PAUSED
//   clear_processed     - pulse, force count to MIN_VAL (beats tick)
//   tick                - step enable
//   dir                 - registered direction (0 = UP, 1 = DOWN)
//   running             - registered run state (1 = RUNNING)
//   count               - registered count value
//   limit_hit           - one-cycle pulse after a step attempted at the limit
module updown_counter_fsm
    import updown_counter_fsm_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 9,
    parameter int MODE    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             increase_processed,
    input  logic             decrease_processed,
    input  logic             pause_processed,
    input  logic             clear_processed,
    input  logic             tick,
    output logic             dir,
    output logic             running,
    output logic [WIDTH-1:0] count,
    output logic             limit_hit
);

    localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    run_e             run_q;
    run_e             run_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             limit_hit_q;
    logic             limit_hit_d;
    logic             dir_s;
    logic             step_s;
    logic             at_limit_s;
    logic             auto_flip_s;

    dir_state_fsm u_dir (
        .clk         (clk),
        .rst         (rst),
        .increase_i  (increase_processed),
        .decrease_i  (decrease_processed),
        .auto_flip_i (auto_flip_s),
        .dir_o       (dir_s)
    );

    // Run state, count and limit event registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q       <= PAUSED;
            count_q     <= MIN_C;
            limit_hit_q <= 1'b0;
        end else begin
            run_q       <= run_d;
            count_q     <= count_d;
            limit_hit_q <= limit_hit_d;
        end
    end

    // Run toggle, step decision and count datapath; the limit is checked
    // before adding so the count never leaves [MIN_VAL, MAX_VAL].
    always_comb begin
        run_d       = run_q;
        count_d     = count_q;
        limit_hit_d = 1'b0;
        auto_flip_s = 1'b0;
        step_s      = tick && (run_q == RUNNING) && !clear_processed;
        at_limit_s  = (dir_s == UP) ? (count_q == MAX_C) : (count_q == MIN_C);

        if (pause_processed) begin
            run_d = (run_q == RUNNING) ? PAUSED : RUNNING;
        end else begin
            run_d = run_q;
        end

        if (clear_processed) begin
            count_d = MIN_C;
        end else if (step_s && at_limit_s) begin
            limit_hit_d = 1'b1;
            case (MODE)
                MODE_WRAP: begin
                    count_d = (dir_s == UP) ? MIN_C : MAX_C;
                end
                MODE_SAT: begin
                    count_d = count_q;
                end
                MODE_BOUNCE: begin
                    count_d     = (dir_s == UP) ? (MAX_C - ONE_C) : (MIN_C + ONE_C);
                    auto_flip_s = 1'b1;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end else if (step_s) begin
            count_d = (dir_s == UP) ? (count_q + ONE_C) : (count_q - ONE_C);
        end else begin
            count_d = count_q;
        end
    end

    assign dir       = dir_s;
    assign running   = run_q;
    assign count     = count_q;
    assign limit_hit = limit_hit_q;

endmodule

// File: tb/tb_updown_counter_fsm.sv
// Bench for updown_counter_fsm: three instances (wrap, saturate, bounce)
// share one stimulus stream; a vector table holds hand-computed results.
module tb_updown_counter_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic       pau = 1'b0;
    logic       clr = 1'b0;
    logic       tck = 1'b0;
    logic       dir_w [3];
    logic       run_w [3];
    logic [3:0] cnt_w [3];
    logic       lh_w  [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    updown_counter_fsm #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .MODE(0)) u_wrap (
        .clk(clk), .rst(rst), .increase_processed(inc), .decrease_processed(dec),
        .pause_processed(pau), .clear_processed(clr), .tick(tck),
        .dir(dir_w[0]), .running(run_w[0]), .count(cnt_w[0]), .limit_hit(lh_w[0]));

    updown_counter_fsm #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .MODE(1)) u_sat (
        .clk(clk), .rst(rst), .increase_processed(inc), .decrease_processed(dec),
        .pause_processed(pau), .clear_processed(clr), .tick(tck),
        .dir(dir_w[1]), .running(run_w[1]), .count(cnt_w[1]), .limit_hit(lh_w[1]));

    updown_counter_fsm #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .MODE(2)) u_bnc (
        .clk(clk), .rst(rst), .increase_processed(inc), .decrease_processed(dec),
        .pause_processed(pau), .clear_processed(clr), .tick(tck),
        .dir(dir_w[2]), .running(run_w[2]), .count(cnt_w[2]), .limit_hit(lh_w[2]));

    typedef struct {
        logic inc, dec, pau, clr, tck;
        logic run;
        logic d0, d1, d2;
        int   c0, c1, c2;
        logic l0, l1, l2;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic i, input logic d, input logic p, input logic c,
                       input logic t, input logic r,
                       input logic d0, input logic d1, input logic d2,
                       input int c0, input int c1, input int c2,
                       input logic l0, input logic l1, input logic l2);
        vec_t v;
        v.inc = i; v.dec = d; v.pau = p; v.clr = c; v.tck = t; v.run = r;
        v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.c0 = c0; v.c1 = c1; v.c2 = c2;
        v.l0 = l0; v.l1 = l1; v.l2 = l2;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare all three instances against one common set of expectations.
    task automatic check_all(input string tag, input int d, input int r, input int c, input int l);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s u%0d dir", tag, k), int'(dir_w[k]), d);
            check($sformatf("%s u%0d running", tag, k), int'(run_w[k]), r);
            check($sformatf("%s u%0d count", tag, k), int'(cnt_w[k]), c);
            check($sformatf("%s u%0d limit_hit", tag, k), int'(lh_w[k]), l);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cycle(input logic i, input logic d, input logic p, input logic c, input logic t);
        inc = i; dec = d; pau = p; clr = c; tck = t;
        @(posedge clk);
        #1;
        inc = 1'b0; dec = 1'b0; pau = 1'b0; clr = 1'b0; tck = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        //   i d p c t  run  dirs    counts   limit_hit
        add(0,0,1,0,0, 1, 0,0,0, 0,0,0, 0,0,0);   // start running
        add(0,0,0,0,1, 1, 0,0,0, 1,1,1, 0,0,0);
        add(0,0,0,0,1, 1, 0,0,0, 2,2,2, 0,0,0);
        add(0,0,0,0,1, 1, 0,0,0, 3,3,3, 0,0,0);
        add(0,0,0,0,1, 1, 0,0,0, 4,4,4, 0,0,0);
        add(0,0,0,0,1, 1, 0,0,0, 5,5,5, 0,0,0);
        add(0,0,0,0,1, 1, 0,0,0, 6,6,6, 0,0,0);
        add(0,0,0,0,1, 1, 0,0,0, 7,7,7, 0,0,0);
        add(0,0,0,0,1, 1, 0,0,0, 8,8,8, 0,0,0);
        add(0,0,0,0,1, 1, 0,0,0, 9,9,9, 0,0,0);
        add(0,0,0,0,1, 1, 0,0,1, 0,9,8, 1,1,1);   // step at MAX
        add(0,0,0,0,1, 1, 0,0,1, 1,9,7, 0,1,0);   // saturate hits again
        add(0,0,0,0,0, 1, 0,0,1, 1,9,7, 0,0,0);   // idle: pulse ends
        add(0,1,0,0,0, 1, 1,1,1, 1,9,7, 0,0,0);   // decrease request
        add(0,0,0,0,1, 1, 1,1,1, 0,8,6, 0,0,0);
        add(0,0,0,0,1, 1, 1,1,1, 9,7,5, 1,0,0);   // wrap below MIN
        add(0,0,0,1,1, 1, 1,1,1, 0,0,0, 0,0,0);   // clear beats tick
        add(0,0,0,0,1, 1, 1,1,0, 9,0,1, 1,1,1);   // step at MIN
        add(1,1,0,0,0, 1, 1,1,0, 9,0,1, 0,0,0);   // both requests: hold
        add(0,0,1,0,0, 0, 1,1,0, 9,0,1, 0,0,0);   // pause
        add(0,0,0,0,1, 0, 1,1,0, 9,0,1, 0,0,0);   // ticks ignored
        add(0,0,0,0,1, 0, 1,1,0, 9,0,1, 0,0,0);
        add(0,0,0,0,1, 0, 1,1,0, 9,0,1, 0,0,0);
        add(1,0,0,0,0, 0, 0,0,0, 9,0,1, 0,0,0);   // direction accepted paused
        add(0,0,0,1,0, 0, 0,0,0, 0,0,0, 0,0,0);   // clear while paused
        add(0,0,1,0,1, 1, 0,0,0, 0,0,0, 0,0,0);   // resume + tick: no step
        add(0,0,0,0,1, 1, 0,0,0, 1,1,1, 0,0,0);

        #2;
        do_reset();
        check_all("reset", 0, 0, 0, 0);

        for (int n = 0; n < tbl.size(); n++) begin
            cycle(tbl[n].inc, tbl[n].dec, tbl[n].pau, tbl[n].clr, tbl[n].tck);
            check($sformatf("v%0d running0", n), int'(run_w[0]), int'(tbl[n].run));
            check($sformatf("v%0d running1", n), int'(run_w[1]), int'(tbl[n].run));
            check($sformatf("v%0d running2", n), int'(run_w[2]), int'(tbl[n].run));
            check($sformatf("v%0d dir0", n), int'(dir_w[0]), int'(tbl[n].d0));
            check($sformatf("v%0d dir1", n), int'(dir_w[1]), int'(tbl[n].d1));
            check($sformatf("v%0d dir2", n), int'(dir_w[2]), int'(tbl[n].d2));
            check($sformatf("v%0d count0", n), int'(cnt_w[0]), tbl[n].c0);
            check($sformatf("v%0d count1", n), int'(cnt_w[1]), tbl[n].c1);
            check($sformatf("v%0d count2", n), int'(cnt_w[2]), tbl[n].c2);
            check($sformatf("v%0d limit_hit0", n), int'(lh_w[0]), int'(tbl[n].l0));
            check($sformatf("v%0d limit_hit1", n), int'(lh_w[1]), int'(tbl[n].l1));
            check($sformatf("v%0d limit_hit2", n), int'(lh_w[2]), int'(tbl[n].l2));
        end

        // Bounce with a same-cycle user request: user keeps UP, count bounces.
        do_reset();
        cycle(0, 0, 1, 0, 0);
        repeat (9) cycle(0, 0, 0, 0, 1);
        check_all("at nine", 0, 1, 9, 0);
        cycle(1, 0, 0, 0, 1);
        check("bounce+inc dir", int'(dir_w[2]), 0);
        check("bounce+inc count", int'(cnt_w[2]), 8);
        check("bounce+inc limit_hit", int'(lh_w[2]), 1);

        // Asynchronous reset mid-run at count 7, observed before any edge.
        do_reset();
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        repeat (7) cycle(0, 0, 0, 0, 1);
        check_all("pre-reset", 0, 1, 7, 0);
        cycle(0, 1, 0, 0, 0);
        check_all("pre-reset down", 1, 1, 7, 0);
        rst = 1'b0;
        #1;
        check_all("async reset", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(0, 0, 0, 0, 1);
        check_all("post-reset tick", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/updown_counter_fsm.md
Name: updown_counter_fsm

Overview:
Parametrised up/down counter with an integrated direction state machine and a run/pause state machine.
- Consumes one-cycle debounced/one-pulsed button pulses (increase, decrease, pause, clear) and a periodic tick.
- Steps a bounded count value and reports direction, run state and limit events.
- Sits between the button-processing front end and the display/BCD back end.
- Limit handling is selectable: wrap, saturate or bounce (auto-reverse).

Parameters:
WIDTH, 4, count width in bits
MIN_VAL, 0, lower bound of count; constraint MIN_VAL < MAX_VAL
MAX_VAL, 9, upper bound of count; constraint MAX_VAL <= 2^WIDTH-1
MODE, 0, limit policy: 0 = wrap, 1 = saturate, 2 = bounce

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
increase_processed  input  1  one-cycle pulse, request direction UP
decrease_processed  input  1  one-cycle pulse, request direction DOWN
pause_processed  input  1  one-cycle pulse, toggle RUNNING/PAUSED
clear_processed  input  1  one-cycle pulse, force count to MIN_VAL
tick  input  1  one-cycle step enable from the clock divider
dir  output  1  current direction: 0 = UP, 1 = DOWN
running  output  1  1 = RUNNING, 0 = PAUSED
count  output  WIDTH  current count value
limit_hit  output  1  one-cycle pulse when a step is attempted at the limit in the travel direction

Behaviour:
- Clocking: all state updates on posedge clk. rst is asynchronous, active-low; clock clk.
- Reset values: dir = UP (0), running = 0 (PAUSED), count = MIN_VAL, limit_hit = 0. Reset mid-count returns immediately to these values with no further steps.
- Direction FSM, states UP/DOWN:
  - In UP, decrease_processed -> DOWN.
  - In DOWN, increase_processed -> UP.
  - increase and decrease both asserted in the same cycle -> hold current state.
  - A new direction takes effect the cycle after the pulse.
- Run FSM, states PAUSED/RUNNING: pause_processed toggles the state; takes effect next cycle.
- Step rule: a step occurs when tick = 1, running = 1 (registered value) and clear_processed = 0. The step uses the registered dir, never the same-cycle request.
- Normal step: UP gives count+1; DOWN gives count-1. No intermediate overflow, because the limit check comes before the add.
- At limit (UP with count == MAX_VAL, or DOWN with count == MIN_VAL) with a step:
  - limit_hit = 1 in the next cycle, for exactly one cycle.
  - MODE 0 (wrap): UP loads MIN_VAL; DOWN loads MAX_VAL.
  - MODE 1 (saturate): count holds.
  - MODE 2 (bounce): dir flips; count moves one step in the new direction (MAX_VAL-1 or MIN_VAL+1).
- Bounce with a same-cycle user direction pulse: the user pulse decides the next dir. The count still follows the bounce rule.
- clear_processed has priority over tick:
  - count <= MIN_VAL; dir and running are unchanged; limit_hit = 0.
  - Clear works while PAUSED.
- While PAUSED, tick is ignored. Direction requests are still accepted.
- tick with running = 0 in the same cycle as pause_processed: no step. Stepping starts on the first tick after running reads 1.
- Output timing: all outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared header/package holds:
  - direction encodings `UP = 1'b0`, `DOWN = 1'b1`
  - run encodings `PAUSED = 1'b0`, `RUNNING = 1'b1`
  - mode constants `MODE_WRAP = 0`, `MODE_SAT = 1`, `MODE_BOUNCE = 2`
- One natural sub-module: dir_state_fsm.
  - Holds the UP/DOWN register and its next-state logic.
  - Inputs: the increase/decrease pulses plus an auto_flip input driven by bounce logic.
- The top level holds the run FSM, the count datapath and limit_hit.

Test Plan:
All scenarios use WIDTH=4, MIN_VAL=0, MAX_VAL=9.
1. Reset, then pause pulse, then 3 ticks (MODE 0) -> running = 1; count 0 -> 1 -> 2 -> 3; dir = 0; limit_hit stays 0.
2. MODE 0: count = 9, UP, tick -> count = 0 with a one-cycle limit_hit. Then decrease pulse and tick -> count = 9 with limit_hit = 1.
3. MODE 1: count = 9, UP, 2 ticks -> count stays 9; limit_hit pulses once per tick. Then decrease pulse and tick -> count = 8.
4. MODE 2: count = 9, UP, tick -> dir = 1, count = 8. At count = 0, DOWN, tick -> dir = 0, count = 1.
5. increase and decrease asserted together in DOWN -> dir stays 1. Clear asserted together with tick at count = 5 -> count = 0, no step, limit_hit = 0.
6. Paused at count = 4: 5 ticks -> count stays 4. Assert rst low mid-run at count = 7 -> count = 0, dir = 0, running = 0 immediately, without waiting for a clock edge.
